// File: rtl/perf_event_counters_if.sv
// Snapshot readout port of the event counter bank.
// The consumer (master) requests and releases snapshots and selects a channel.
// The counter bank (slave) holds the snapshot and returns the selected channel's value.
interface perf_event_counters_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 64
);
    localparam int RD_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              snap_req;
    logic              snap_valid;
    logic              snap_ready;
    logic [RD_W-1:0]   rd_idx;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_ovf;

    modport master (
        output snap_req, snap_ready, rd_idx,
        input  snap_valid, rd_data, rd_ovf
    );

    modport slave (
        input  snap_req, snap_ready, rd_idx,
        output snap_valid, rd_data, rd_ovf
    );
endinterface

// File: rtl/perf_event_counters.sv
// Bank of per-channel event counters with a valid/ready snapshot readout
// and a forward-progress watchdog. Single clock, synchronous active-high reset.

// One counter channel: accumulates a multi-count event each cycle.
// Overflow is sticky; the counter either wraps or clamps at all-ones.
module perf_event_counters_lane #(
    parameter int CNT_W    = 64,
    parameter int AMT_W    = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             ev_valid_i,
    input  logic [AMT_W-1:0] ev_amt_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W:0]   sum;
    logic             carry;

    // One extra bit so the carry out of the counter is visible.
    assign sum   = {1'b0, cnt_q} + (CNT_W+1)'(ev_amt_i);
    assign carry = sum[CNT_W];

    // Next-state: clear drops the event; a zero amount leaves everything as is.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (ev_valid_i) begin
            if (carry) begin
                ovf_d = 1'b1;
                cnt_d = (SATURATE != 0) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
            end else begin
                cnt_d = sum[CNT_W-1:0];
            end
        end
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
endmodule

module perf_event_counters #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 64,
    parameter int AMT_W       = 2,
    parameter int SATURATE    = 0,
    parameter int WDOG_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ev_valid_i,
    input  logic [NUM_CH*AMT_W-1:0] ev_amt_i,
    input  logic                    clear_i,
    input  logic                    progress_i,
    perf_event_counters_if.slave    snap_if,
    output logic                    timeout_o
);
    localparam int RD_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // A zero cycle count still needs a one-bit idle counter to stay legal.
    localparam int IDLE_W = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam bit WD_EN  = (WDOG_CYCLES > 0);
    localparam logic [IDLE_W-1:0] WDOG_MAX = IDLE_W'(WDOG_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HELD = 1'b1
    } snap_st_e;

    // ---------------- live counters ----------------
    logic [NUM_CH-1:0][CNT_W-1:0] live_cnt;
    logic [NUM_CH-1:0]            live_ovf;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        perf_event_counters_lane #(
            .CNT_W    (CNT_W),
            .AMT_W    (AMT_W),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clear_i    (clear_i),
            .ev_valid_i (ev_valid_i[g]),
            .ev_amt_i   (ev_amt_i[g*AMT_W +: AMT_W]),
            .cnt_o      (live_cnt[g]),
            .ovf_o      (live_ovf[g])
        );
    end

    // ---------------- snapshot ----------------
    snap_st_e                     st_q;
    logic                         snap_valid_q;
    logic [NUM_CH-1:0][CNT_W-1:0] snap_cnt_q;
    logic [NUM_CH-1:0]            snap_ovf_q;

    // Snapshot FSM: captures pre-update (and pre-clear) register values.
    // While HELD, a request only counts together with ready (release + recapture).
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= S_IDLE;
            snap_valid_q <= 1'b0;
            snap_cnt_q   <= '0;
            snap_ovf_q   <= '0;
        end else begin
            case (st_q)
                S_IDLE: begin
                    if (snap_if.snap_req) begin
                        st_q         <= S_HELD;
                        snap_valid_q <= 1'b1;
                        snap_cnt_q   <= live_cnt;
                        snap_ovf_q   <= live_ovf;
                    end
                end
                S_HELD: begin
                    if (snap_if.snap_ready) begin
                        if (snap_if.snap_req) begin
                            snap_cnt_q <= live_cnt;
                            snap_ovf_q <= live_ovf;
                        end else begin
                            st_q         <= S_IDLE;
                            snap_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    st_q         <= S_IDLE;
                    snap_valid_q <= 1'b0;
                end
            endcase
        end
    end

    logic [CNT_W-1:0] rd_data_c;
    logic             rd_ovf_c;

    // Readout mux; indices past the last channel match nothing and read 0.
    always_comb begin
        rd_data_c = '0;
        rd_ovf_c  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (snap_if.rd_idx == RD_W'(i)) begin
                rd_data_c = snap_cnt_q[i];
                rd_ovf_c  = snap_ovf_q[i];
            end
        end
    end

    assign snap_if.snap_valid = snap_valid_q;
    assign snap_if.rd_data    = rd_data_c;
    assign snap_if.rd_ovf     = rd_ovf_c;

    // ---------------- watchdog ----------------
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;

    // Idle counter saturates at the limit. Timeout is set from the next idle
    // value so it is visible exactly WDOG_CYCLES cycles after progress stops.
    always_comb begin
        idle_d = idle_q;
        if (clear_i || progress_i)
            idle_d = '0;
        else if (idle_q != WDOG_MAX)
            idle_d = idle_q + 1'b1;

        if (clear_i)
            timeout_d = 1'b0;
        else
            timeout_d = timeout_q | (WD_EN && (idle_d == WDOG_MAX));
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
endmodule

// File: tb/tb_perf_event_counters.sv
// Bench for perf_event_counters: a wrap-mode and a saturate-mode instance
// (4 channels, 4-bit counters, watchdog of 8) driven with identical stimulus.
module tb_perf_event_counters;
    localparam int NCH = 4;
    localparam int CW  = 4;
    localparam int WD  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] ev_valid;
    logic [NCH*2-1:0] ev_amt;
    logic           clear, progress, snap_req, snap_ready;
    logic [1:0]     rd_idx;
    logic           w_to, s_to;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    perf_event_counters_if #(.NUM_CH(NCH), .CNT_W(CW)) w_if ();
    perf_event_counters_if #(.NUM_CH(NCH), .CNT_W(CW)) s_if ();

    assign w_if.snap_req   = snap_req;
    assign w_if.snap_ready = snap_ready;
    assign w_if.rd_idx     = rd_idx;
    assign s_if.snap_req   = snap_req;
    assign s_if.snap_ready = snap_ready;
    assign s_if.rd_idx     = rd_idx;

    perf_event_counters #(.NUM_CH(NCH), .CNT_W(CW), .AMT_W(2), .SATURATE(0), .WDOG_CYCLES(WD)) u_wrap (
        .clk(clk), .rst(rst), .ev_valid_i(ev_valid), .ev_amt_i(ev_amt), .clear_i(clear),
        .progress_i(progress), .snap_if(w_if), .timeout_o(w_to));

    perf_event_counters #(.NUM_CH(NCH), .CNT_W(CW), .AMT_W(2), .SATURATE(1), .WDOG_CYCLES(WD)) u_sat (
        .clk(clk), .rst(rst), .ev_valid_i(ev_valid), .ev_amt_i(ev_amt), .clear_i(clear),
        .progress_i(progress), .snap_if(s_if), .timeout_o(s_to));

    // Directed snapshot read table: phase selects which scenario it belongs to.
    typedef struct {
        int         phase;
        logic [1:0] idx;
        logic [3:0] wd;
        logic       wo;
        logic [3:0] sd;
        logic       so;
    } rd_vec_t;
    rd_vec_t rd_tab[$];

    // Scoreboard entry: the expected snapshot of both instances.
    typedef struct {
        int cnt [2][NCH];
        bit ovf [2][NCH];
    } snap_t;
    snap_t sb_q[$];

    // Reference state
    int m_cnt [2][NCH];
    bit m_ovf [2][NCH];
    bit m_held;
    int m_idle;
    bit m_to;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NCH; c++) begin
                m_cnt[m][c] = 0;
                m_ovf[m][c] = 1'b0;
            end
        m_held = 1'b0;
        m_idle = 0;
        m_to   = 1'b0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, " w snap_valid"}, 32'(w_if.snap_valid), 32'(m_held));
        chk({tag, " s snap_valid"}, 32'(s_if.snap_valid), 32'(m_held));
        chk({tag, " w timeout"},    32'(w_to), 32'(m_to));
        chk({tag, " s timeout"},    32'(s_to), 32'(m_to));
    endtask

    // Pop the oldest expected snapshot and compare every channel of both instances.
    task automatic check_snap();
        snap_t s;
        if (sb_q.size() == 0) begin
            chk("sb underflow", 32'd1, 32'd0);
            return;
        end
        s = sb_q.pop_front();
        for (int c = 0; c < NCH; c++) begin
            rd_idx = 2'(c);
            #1;
            chk($sformatf("sb w data ch%0d", c), 32'(w_if.rd_data), 32'(s.cnt[0][c]));
            chk($sformatf("sb w ovf ch%0d", c),  32'(w_if.rd_ovf),  32'(s.ovf[0][c]));
            chk($sformatf("sb s data ch%0d", c), 32'(s_if.rd_data), 32'(s.cnt[1][c]));
            chk($sformatf("sb s ovf ch%0d", c),  32'(s_if.rd_ovf),  32'(s.ovf[1][c]));
        end
    endtask

    task automatic check_phase(input int p);
        foreach (rd_tab[k]) begin
            if (rd_tab[k].phase == p) begin
                rd_idx = rd_tab[k].idx;
                #1;
                chk($sformatf("p%0d w data idx%0d", p, rd_tab[k].idx), 32'(w_if.rd_data), 32'(rd_tab[k].wd));
                chk($sformatf("p%0d w ovf idx%0d", p, rd_tab[k].idx),  32'(w_if.rd_ovf),  32'(rd_tab[k].wo));
                chk($sformatf("p%0d s data idx%0d", p, rd_tab[k].idx), 32'(s_if.rd_data), 32'(rd_tab[k].sd));
                chk($sformatf("p%0d s ovf idx%0d", p, rd_tab[k].idx),  32'(s_if.rd_ovf),  32'(rd_tab[k].so));
            end
        end
    endtask

    // Drive one cycle, advance the reference, then check status and any capture.
    task automatic cyc(input logic [3:0] v, input logic [7:0] a, input logic clr,
                       input logic prog, input logic req, input logic rdy);
        bit cap;
        snap_t s;
        int amt, sum;
        ev_valid = v; ev_amt = a; clear = clr; progress = prog;
        snap_req = req; snap_ready = rdy;

        cap = req && (!m_held || rdy);
        if (cap) begin
            s.cnt = m_cnt;
            s.ovf = m_ovf;
            sb_q.push_back(s);
        end
        if (!m_held) m_held = req;
        else if (rdy && !req) m_held = 1'b0;

        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NCH; c++) begin
                amt = int'((a >> (2*c)) & 8'h3);
                if (clr) begin
                    m_cnt[m][c] = 0;
                    m_ovf[m][c] = 1'b0;
                end else if (v[c]) begin
                    sum = m_cnt[m][c] + amt;
                    if (sum > 15) begin
                        m_ovf[m][c] = 1'b1;
                        m_cnt[m][c] = (m == 0) ? sum - 16 : 15;
                    end else begin
                        m_cnt[m][c] = sum;
                    end
                end
            end

        if (clr) begin
            m_idle = 0;
            m_to   = 1'b0;
        end else begin
            m_idle = prog ? 0 : m_idle + 1;
            if (m_idle >= WD) m_to = 1'b1;
        end

        @(posedge clk);
        #1;
        chk_status("cyc");
        if (cap) check_snap();
    endtask

    // Reset with every other input active to show reset dominates.
    task automatic do_rst(input int n);
        rst = 1'b1;
        ev_valid = '1; ev_amt = '1; clear = 1'b1; progress = 1'b0;
        snap_req = 1'b1; snap_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        ev_valid = '0; ev_amt = '0; clear = 1'b0; progress = 1'b1;
        snap_req = 1'b0; snap_ready = 1'b0;
        model_reset();
        chk_status("rst");
    endtask

    initial begin
        // phase 0: accumulate snapshot
        rd_tab.push_back('{0, 2'd0, 4'd12, 1'b0, 4'd12, 1'b0});
        rd_tab.push_back('{0, 2'd1, 4'd2,  1'b0, 4'd2,  1'b0});
        rd_tab.push_back('{0, 2'd2, 4'd0,  1'b0, 4'd0,  1'b0});
        rd_tab.push_back('{0, 2'd3, 4'd0,  1'b0, 4'd0,  1'b0});
        // phase 1: 14 + 3 overflow
        rd_tab.push_back('{1, 2'd0, 4'd1,  1'b1, 4'd15, 1'b1});
        rd_tab.push_back('{1, 2'd1, 4'd2,  1'b0, 4'd2,  1'b0});
        // phase 2: clear + event + request captures pre-clear value
        rd_tab.push_back('{2, 2'd0, 4'd5,  1'b0, 4'd5,  1'b0});
        // phase 3: following snapshot sees the cleared counter
        rd_tab.push_back('{3, 2'd0, 4'd0,  1'b0, 4'd0,  1'b0});
        // phase 4: request while held without ready leaves data unchanged
        rd_tab.push_back('{4, 2'd2, 4'd0,  1'b0, 4'd0,  1'b0});
        // phase 5: everything zero after reset
        rd_tab.push_back('{5, 2'd0, 4'd0,  1'b0, 4'd0,  1'b0});
        rd_tab.push_back('{5, 2'd1, 4'd0,  1'b0, 4'd0,  1'b0});
        rd_tab.push_back('{5, 2'd2, 4'd0,  1'b0, 4'd0,  1'b0});
        rd_tab.push_back('{5, 2'd3, 4'd0,  1'b0, 4'd0,  1'b0});

        rd_idx = 2'd0;
        model_reset();
        do_rst(2);
        check_phase(5);

        // Accumulate: ch0 +3 x4, ch1 +1 x2; zero-amount and invalid events are no-ops
        cyc(4'b0011, 8'h07, 0, 1, 0, 0);
        cyc(4'b0011, 8'h07, 0, 1, 0, 0);
        cyc(4'b1001, 8'h03, 0, 1, 0, 0);
        cyc(4'b0001, 8'hC3, 0, 1, 0, 0);
        cyc(4'b0000, 8'hFF, 0, 1, 0, 0);
        cyc(4'b0000, 8'h00, 0, 1, 1, 0);
        check_phase(0);
        cyc(4'b0000, 8'h00, 0, 1, 0, 1);

        // Overflow: 12 + 2 = 14, then + 3
        cyc(4'b0001, 8'h02, 0, 1, 0, 0);
        cyc(4'b0001, 8'h03, 0, 1, 0, 0);
        cyc(4'b0000, 8'h00, 0, 1, 1, 0);
        check_phase(1);
        cyc(4'b0000, 8'h00, 0, 1, 0, 1);

        // Simultaneous clear + event + request with ch0 = 5
        cyc(4'b0000, 8'h00, 1, 1, 0, 0);
        cyc(4'b0001, 8'h03, 0, 1, 0, 0);
        cyc(4'b0001, 8'h02, 0, 1, 0, 0);
        cyc(4'b0001, 8'h02, 1, 1, 1, 0);
        check_phase(2);
        cyc(4'b0000, 8'h00, 0, 1, 0, 1);
        cyc(4'b0000, 8'h00, 0, 1, 1, 0);
        check_phase(3);

        // Handshake while held
        cyc(4'b0100, 8'h10, 0, 1, 0, 0);
        cyc(4'b0000, 8'h00, 0, 1, 1, 0);
        check_phase(4);
        cyc(4'b0000, 8'h00, 0, 1, 1, 1);
        cyc(4'b0000, 8'h00, 0, 1, 0, 1);
        chk("release snap_valid", 32'(w_if.snap_valid), 32'd0);

        // Watchdog: pulses every 7 cycles never time out
        for (int i = 0; i < 29; i++)
            cyc(4'b0000, 8'h00, 0, (i % 7) == 0, 0, 0);
        cyc(4'b0000, 8'h00, 0, 1, 0, 0);
        chk("wdog pulses no timeout", 32'(w_to), 32'd0);
        for (int k = 1; k <= WD; k++) begin
            cyc(4'b0000, 8'h00, 0, 0, 0, 0);
            if (k == WD - 1) chk("wdog t+7", 32'(w_to), 32'd0);
        end
        chk("wdog t+8", 32'(w_to), 32'd1);
        chk("wdog t+8 sat", 32'(s_to), 32'd1);
        repeat (3) cyc(4'b0000, 8'h00, 0, 1, 0, 0);
        chk("wdog sticky", 32'(w_to), 32'd1);
        cyc(4'b0000, 8'h00, 1, 1, 0, 0);
        chk("wdog clear", 32'(w_to), 32'd0);

        // Reset while held, with live counts and timeout set
        cyc(4'b0001, 8'h03, 0, 1, 0, 0);
        repeat (WD) cyc(4'b0000, 8'h00, 0, 0, 0, 0);
        cyc(4'b0000, 8'h00, 0, 0, 1, 0);
        chk("pre-rst timeout", 32'(w_to), 32'd1);
        do_rst(1);
        chk("post-rst snap_valid", 32'(s_if.snap_valid), 32'd0);
        check_phase(5);
        cyc(4'b0000, 8'h00, 0, 1, 1, 0);
        cyc(4'b0000, 8'h00, 0, 1, 0, 1);

        chk("sb drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
